// File: rtl/oled_cmd_pkg.sv
// Shared constants, state encoding and descriptor bundle
// for the OLED command frame parser.
package oled_cmd_pkg;

    localparam int MAX_PAYLOAD = 31;
    localparam int X_MAX       = 127;
    localparam int Y_MAX       = 7;

    localparam logic [7:0] START_BYTE = 8'h00;
    localparam logic [7:0] END_BYTE   = 8'hFF;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_INIT  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_TEXT  = 2'd3;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_TAG      = 3'd1;
    localparam logic [2:0] ERR_FONT     = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_FIELD    = 3'd4;
    localparam logic [2:0] ERR_RANGE    = 3'd5;
    localparam logic [2:0] ERR_EMPTY    = 3'd6;

    localparam int OFS_TAG  = 0;
    localparam int OFS_FONT = 3;
    localparam int OFS_X2   = 4;
    localparam int OFS_X1   = 5;
    localparam int OFS_X0   = 6;
    localparam int OFS_Y    = 7;
    localparam int OFS_CHAR = 8;

    localparam logic [7:0] A_0     = 8'h30;
    localparam logic [7:0] A_2     = 8'h32;
    localparam logic [7:0] A_3     = 8'h33;
    localparam logic [7:0] A_9     = 8'h39;
    localparam logic [7:0] A_A     = 8'h41;
    localparam logic [7:0] A_C     = 8'h43;
    localparam logic [7:0] A_E     = 8'h45;
    localparam logic [7:0] A_G     = 8'h47;
    localparam logic [7:0] A_I     = 8'h49;
    localparam logic [7:0] A_M     = 8'h4D;
    localparam logic [7:0] A_N     = 8'h4E;
    localparam logic [7:0] A_R     = 8'h52;
    localparam logic [7:0] A_SPACE = 8'h20;

    localparam logic [7:0] SIZE_ENG2 = 8'd33;
    localparam logic [7:0] SIZE_ENG3 = 8'd73;
    localparam logic [7:0] SIZE_MAR3 = 8'd70;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_COLLECT,
        ST_DECODE,
        ST_ISSUE,
        ST_PRESENT
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic       lang;
        logic [1:0] font;
        logic [7:0] char_size;
        logic [6:0] x;
        logic [2:0] y;
        logic [4:0] len;
    } cmd_desc_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= A_0) && (b <= A_9);
    endfunction

endpackage

// File: rtl/cmd_field_decode.sv
// Combinational decode of the first eight payload bytes
// into a command descriptor or an error code.
module cmd_field_decode
    import oled_cmd_pkg::*;
(
    input  logic [7:0][7:0] hdr,
    input  logic [4:0]      count,
    output cmd_desc_t       desc,
    output logic            err,
    output logic [2:0]      err_code
);

    logic       is_eng;
    logic       is_mar;
    logic       font_ok;
    logic [1:0] font_code;
    logic [7:0] size_sel;
    logic [3:0] d2, d1, d0, dy;
    logic       x_digits;
    logic       y_ok;
    logic [9:0] x_full;

    always_comb begin
        is_eng = (count >= 5'd3) && (hdr[0] == A_E)
              && (hdr[1] == A_N) && (hdr[2] == A_G);
        is_mar = (count >= 5'd3) && (hdr[0] == A_M)
              && (hdr[1] == A_A) && (hdr[2] == A_R);

        font_ok   = 1'b0;
        font_code = 2'd0;
        size_sel  = 8'd0;
        if (is_eng && hdr[OFS_FONT] == A_2) begin
            font_ok   = 1'b1;
            font_code = 2'd2;
            size_sel  = SIZE_ENG2;
        end else if (is_eng && hdr[OFS_FONT] == A_3) begin
            font_ok   = 1'b1;
            font_code = 2'd3;
            size_sel  = SIZE_ENG3;
        end else if (is_mar && hdr[OFS_FONT] == A_3) begin
            font_ok   = 1'b1;
            font_code = 2'd3;
            size_sel  = SIZE_MAR3;
        end

        d2 = 4'(hdr[OFS_X2] - A_0);
        d1 = 4'(hdr[OFS_X1] - A_0);
        d0 = 4'(hdr[OFS_X0] - A_0);
        dy = 4'(hdr[OFS_Y] - A_0);
        x_digits = is_digit(hdr[OFS_X2]) && is_digit(hdr[OFS_X1])
                && is_digit(hdr[OFS_X0]);
        y_ok   = is_digit(hdr[OFS_Y]) && (dy <= 4'(Y_MAX));
        x_full = 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
    end

    always_comb begin
        desc     = '0;
        err      = 1'b0;
        err_code = ERR_NONE;
        if (count == 5'd0) begin
            err      = 1'b1;
            err_code = ERR_EMPTY;
        end else begin
            unique case (1'b1)
                (hdr[OFS_TAG] == A_C): desc.op = OP_CLEAR;
                (hdr[OFS_TAG] == A_I): desc.op = OP_INIT;
                (is_eng || is_mar): begin
                    // header bytes are only meaningful once a character exists
                    if (count <= 5'(OFS_CHAR)) begin
                        err      = 1'b1;
                        err_code = ERR_FIELD;
                    end else if (!font_ok) begin
                        err      = 1'b1;
                        err_code = ERR_FONT;
                    end else if (!x_digits || !y_ok) begin
                        err      = 1'b1;
                        err_code = ERR_FIELD;
                    end else if (x_full > 10'(X_MAX)) begin
                        err      = 1'b1;
                        err_code = ERR_RANGE;
                    end else begin
                        desc.op        = OP_TEXT;
                        desc.lang      = is_mar;
                        desc.font      = font_code;
                        desc.char_size = size_sel;
                        desc.x         = x_full[6:0];
                        desc.y         = dy[2:0];
                        desc.len       = count - 5'(OFS_CHAR);
                    end
                end
                default: begin
                    err      = 1'b1;
                    err_code = ERR_TAG;
                end
            endcase
        end
    end

endmodule

// File: rtl/oled_cmd_frame_parser.sv
// Frame collector, decode sequencing and command handshake
// in front of the OLED controller.
module oled_cmd_frame_parser
    import oled_cmd_pkg::*;
(
    input  logic       reset,
    input  logic       controller_clock,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic       cmd_lang,
    output logic [1:0] cmd_font,
    output logic [7:0] cmd_char_size,
    output logic [6:0] cmd_x,
    output logic [2:0] cmd_y,
    output logic [4:0] cmd_len,
    input  logic [4:0] char_rd_idx,
    output logic [7:0] char_rd_data,
    output logic       err_pulse,
    output logic [2:0] err_code
);

    state_t          state, state_nx;
    logic [7:0]      buf_mem [MAX_PAYLOAD];
    logic [4:0]      wr_idx;
    logic [7:0][7:0] hdr;
    cmd_desc_t       desc, dec_desc;
    logic            dec_err, err_q;
    logic [2:0]      dec_code, code_q;
    logic            xfer, is_start, is_end, full;
    logic [5:0]      rd_addr;

    assign xfer     = in_valid && in_ready;
    assign is_start = (in_byte == START_BYTE);
    assign is_end   = (in_byte == END_BYTE);
    assign full     = (wr_idx == 5'(MAX_PAYLOAD));

    always_comb begin
        for (int i = 0; i < 8; i++) hdr[i] = buf_mem[i];
    end

    cmd_field_decode u_dec (
        .hdr      (hdr),
        .count    (wr_idx),
        .desc     (dec_desc),
        .err      (dec_err),
        .err_code (dec_code)
    );

    always_ff @(posedge controller_clock or posedge reset) begin
        if (reset) state <= ST_HUNT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        cmd_valid = 1'b0;
        unique case (state)
            ST_HUNT: begin
                in_ready = 1'b1;
                if (xfer && is_start) state_nx = ST_COLLECT;
            end
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (xfer && !is_start) begin
                    if (is_end)    state_nx = ST_DECODE;
                    else if (full) state_nx = ST_HUNT;
                end
            end
            ST_DECODE: state_nx = ST_ISSUE;
            ST_ISSUE:  state_nx = err_q ? ST_HUNT : ST_PRESENT;
            ST_PRESENT: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_nx = ST_HUNT;
            end
            default: state_nx = ST_HUNT;
        endcase
    end

    always_ff @(posedge controller_clock) begin
        if (xfer && state == ST_COLLECT && !is_start && !is_end && !full)
            buf_mem[wr_idx] <= in_byte;
    end

    always_ff @(posedge controller_clock or posedge reset) begin
        if (reset) begin
            wr_idx    <= '0;
            desc      <= '0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            err_pulse <= 1'b0;
            if (xfer && is_start) begin
                wr_idx <= '0;
            end else if (xfer && state == ST_COLLECT && !is_end) begin
                if (full) begin
                    err_pulse <= 1'b1;
                    err_code  <= ERR_OVERFLOW;
                end else begin
                    wr_idx <= wr_idx + 5'd1;
                end
            end
            if (state == ST_DECODE) begin
                err_q  <= dec_err;
                code_q <= dec_code;
                if (!dec_err) desc <= dec_desc;
            end
            if (state == ST_ISSUE && err_q) begin
                err_pulse <= 1'b1;
                err_code  <= code_q;
            end
        end
    end

    assign cmd_op        = desc.op;
    assign cmd_lang      = desc.lang;
    assign cmd_font      = desc.font;
    assign cmd_char_size = desc.char_size;
    assign cmd_x         = desc.x;
    assign cmd_y         = desc.y;
    assign cmd_len       = desc.len;

    assign rd_addr = {1'b0, char_rd_idx} + 6'(OFS_CHAR);

    always_comb begin
        char_rd_data = A_SPACE;
        if (char_rd_idx < desc.len && rd_addr < 6'(MAX_PAYLOAD))
            char_rd_data = buf_mem[rd_addr[4:0]];
    end

endmodule

// File: tb/tb_oled_cmd_frame_parser.sv
// Directed bench for oled_cmd_frame_parser: frames, errors,
// handshake, restart, overflow and reset abort.
module tb_oled_cmd_frame_parser;

    logic       reset;
    logic       controller_clock;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_lang;
    logic [1:0] cmd_font;
    logic [7:0] cmd_char_size;
    logic [6:0] cmd_x;
    logic [2:0] cmd_y;
    logic [4:0] cmd_len;
    logic [4:0] char_rd_idx;
    logic [7:0] char_rd_data;
    logic       err_pulse;
    logic [2:0] err_code;

    int total = 0;
    int bad   = 0;

    oled_cmd_frame_parser dut (
        .reset            (reset),
        .controller_clock (controller_clock),
        .in_byte          (in_byte),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_lang         (cmd_lang),
        .cmd_font         (cmd_font),
        .cmd_char_size    (cmd_char_size),
        .cmd_x            (cmd_x),
        .cmd_y            (cmd_y),
        .cmd_len          (cmd_len),
        .char_rd_idx      (char_rd_idx),
        .char_rd_data     (char_rd_data),
        .err_pulse        (err_pulse),
        .err_code         (err_code)
    );

    initial controller_clock = 1'b0;
    always #5 controller_clock = ~controller_clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge controller_clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge controller_clock);
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge controller_clock);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
        @(posedge controller_clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic frame(input string p);
        send(8'h00);
        for (int i = 0; i < p.len(); i++) send(p[i]);
        send(8'hFF);
    endtask

    task automatic settle(input string tag);
        tick();
        chk({tag, "_early"}, 32'({cmd_valid, err_pulse}), 0);
        tick();
    endtask

    task automatic ack(input string tag);
        @(negedge controller_clock);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk({tag, "_ack_valid"}, 32'(cmd_valid), 0);
        chk({tag, "_ack_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        reset       = 1'b1;
        in_byte     = 8'h00;
        in_valid    = 1'b0;
        cmd_ready   = 1'b0;
        char_rd_idx = 5'd0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_op", 32'(cmd_op), 0);
        chk("rst_len", 32'(cmd_len), 0);
        @(negedge controller_clock);
        @(negedge controller_clock);
        reset = 1'b0;

        frame("ENG20503Hi");
        settle("t1");
        chk("t1_valid", 32'(cmd_valid), 1);
        chk("t1_op", 32'(cmd_op), 3);
        chk("t1_lang", 32'(cmd_lang), 0);
        chk("t1_font", 32'(cmd_font), 2);
        chk("t1_size", 32'(cmd_char_size), 33);
        chk("t1_x", 32'(cmd_x), 50);
        chk("t1_y", 32'(cmd_y), 3);
        chk("t1_len", 32'(cmd_len), 2);
        chk("t1_in_ready", 32'(in_ready), 0);
        char_rd_idx = 5'd0;
        #1 chk("t1_ch0", 32'(char_rd_data), 32'h48);
        char_rd_idx = 5'd1;
        #1 chk("t1_ch1", 32'(char_rd_data), 32'h69);
        char_rd_idx = 5'd2;
        #1 chk("t1_ch2", 32'(char_rd_data), 32'h20);
        @(negedge controller_clock);
        in_byte  = 8'h00;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t1_hold_valid", 32'(cmd_valid), 1);
        chk("t1_hold_ready", 32'(in_ready), 0);
        chk("t1_hold_x", 32'(cmd_x), 50);
        ack("t1");

        frame("MAR31277k");
        settle("t2");
        chk("t2_valid", 32'(cmd_valid), 1);
        chk("t2_lang", 32'(cmd_lang), 1);
        chk("t2_font", 32'(cmd_font), 3);
        chk("t2_size", 32'(cmd_char_size), 70);
        chk("t2_x", 32'(cmd_x), 127);
        chk("t2_y", 32'(cmd_y), 7);
        chk("t2_len", 32'(cmd_len), 1);
        char_rd_idx = 5'd0;
        #1 chk("t2_ch0", 32'(char_rd_data), 32'h6B);
        ack("t2");

        frame("MAR31287k");
        settle("t2r");
        chk("t2r_pulse", 32'(err_pulse), 1);
        chk("t2r_code", 32'(err_code), 5);
        chk("t2r_valid", 32'(cmd_valid), 0);
        tick();
        chk("t2r_pulse_off", 32'(err_pulse), 0);
        chk("t2r_code_hold", 32'(err_code), 5);

        frame("MAR21277k");
        settle("tf");
        chk("tf_code", 32'({err_pulse, err_code}), 32'h0A);

        frame("C");
        settle("t3c");
        chk("t3c_valid", 32'(cmd_valid), 1);
        chk("t3c_op", 32'(cmd_op), 2);
        chk("t3c_code_hold", 32'(err_code), 2);
        ack("t3c");
        frame("I");
        settle("t3i");
        chk("t3i_op", 32'({cmd_valid, cmd_op}), 32'h5);
        ack("t3i");
        frame("");
        settle("t3e");
        chk("t3e_code", 32'({err_pulse, err_code}), 32'hE);
        frame("X");
        settle("t3t");
        chk("t3t_code", 32'({err_pulse, err_code}), 32'h9);
        frame("ENG2050");
        settle("t3s");
        chk("t3s_code", 32'({err_pulse, err_code}), 32'hC);

        send(8'h00);
        for (int i = 0; i < 31; i++) send(8'h41);
        chk("t4_no_err", 32'(err_pulse), 0);
        send(8'h41);
        chk("t4_pulse", 32'(err_pulse), 1);
        chk("t4_code", 32'(err_code), 3);
        chk("t4_ready", 32'(in_ready), 1);
        frame("ENG30000A");
        settle("t4n");
        chk("t4n_valid", 32'(cmd_valid), 1);
        chk("t4n_size", 32'(cmd_char_size), 73);
        chk("t4n_x", 32'(cmd_x), 0);
        chk("t4n_y", 32'(cmd_y), 0);
        chk("t4n_len", 32'(cmd_len), 1);
        ack("t4n");

        send(8'h5A);
        send(8'h51);
        send(8'h00);
        send(8'h45);
        send(8'h4E);
        send(8'h47);
        frame("C");
        chk("t5_no_err_a", 32'(err_pulse), 0);
        settle("t5");
        chk("t5_valid", 32'(cmd_valid), 1);
        chk("t5_op", 32'(cmd_op), 2);
        chk("t5_no_err", 32'(err_pulse), 0);
        ack("t5");

        send(8'h00);
        send(8'h45);
        @(negedge controller_clock);
        reset = 1'b1;
        #1;
        chk("t6a_ready", 32'(in_ready), 1);
        chk("t6a_valid", 32'(cmd_valid), 0);
        chk("t6a_err", 32'({err_pulse, err_code}), 0);
        chk("t6a_op", 32'(cmd_op), 0);
        @(negedge controller_clock);
        reset = 1'b0;
        frame("C");
        settle("t6a");
        chk("t6a_op_next", 32'({cmd_valid, cmd_op}), 32'h6);
        @(negedge controller_clock);
        reset = 1'b1;
        #1;
        chk("t6b_valid", 32'(cmd_valid), 0);
        chk("t6b_ready", 32'(in_ready), 1);
        chk("t6b_op", 32'(cmd_op), 0);
        chk("t6b_err", 32'({err_pulse, err_code}), 0);
        @(negedge controller_clock);
        reset = 1'b0;
        tick();
        chk("t6b_no_pulse", 32'(err_pulse), 0);
        frame("ENG20503Hi");
        settle("t6n");
        chk("t6n_valid", 32'(cmd_valid), 1);
        chk("t6n_x", 32'(cmd_x), 50);
        chk("t6n_len", 32'(cmd_len), 2);
        ack("t6n");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oled_cmd_frame_parser.md
Name: oled_cmd_frame_parser

Overview:
- Upstream stage of the OLED controller.
- Consumes UART payload bytes that have already been moved into the controller_clock domain, delimited by 0x00 (start) and 0xFF (end).
- Validates and decodes each frame into a held command descriptor (INIT, CLEAR or TEXT with font, position and string) and releases it to the controller over a valid/ready handshake.
- The controller reads the string characters through a random-access port while it executes the command.

Parameters:
- MAX_PAYLOAD, 31: payload bytes storable per frame.
- X_MAX, 127: largest legal cursor x.
- Y_MAX, 7: largest legal cursor y (page).
- START_BYTE, 8'h00: frame start delimiter.
- END_BYTE, 8'hFF: frame end delimiter.

Ports:
- reset  in  1  asynchronous, active-high reset
- controller_clock  in  1  block clock; all state changes on the rising edge
- in_byte  in  8  received byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  parser accepts in_byte this cycle
- cmd_valid  out  1  descriptor valid, held until accepted
- cmd_ready  in  1  controller accepts the descriptor (asserted on command completion)
- cmd_op  out  2  1=INIT, 2=CLEAR, 3=TEXT
- cmd_lang  out  1  0=English, 1=Marathi
- cmd_font  out  2  font size code (2 or 3)
- cmd_char_size  out  8  glyph record size in bytes: 33, 73 or 70
- cmd_x  out  7  start column
- cmd_y  out  3  page
- cmd_len  out  5  number of TEXT characters
- char_rd_idx  in  5  character index, 0..cmd_len-1
- char_rd_data  out  8  character at char_rd_idx; combinational read
- err_pulse  out  1  one-cycle error strobe
- err_code  out  3  reason for the last error; holds its value until the next error

Behaviour:
- Reset (asynchronous) values:
  - state = HUNT; in_ready = 1; cmd_valid = 0; err_pulse = 0; err_code = 0.
  - All descriptor fields = 0; write index = 0. Buffer contents are undefined.
- Transfer rule: a byte transfers on an edge where in_valid and in_ready are both high. in_ready = 1 in HUNT and COLLECT, 0 in DECODE and PRESENT.
- HUNT:
  - START_BYTE -> COLLECT, index = 0.
  - Any other byte is discarded.
- COLLECT:
  - START_BYTE -> restart, index = 0, no error.
  - END_BYTE -> DECODE.
  - Other bytes -> stored at buf[index], index+1.
  - A 32nd data byte -> err OVERFLOW(3), go to HUNT.
- DECODE: one cycle, single-cycle decode. The payload layout is:
  - "ENG" or "MAR" (bytes 0-2), font ASCII (byte 3), x as 3 ASCII digits (bytes 4-6), y ASCII (byte 7), characters (bytes 8..).
  - "C" at byte 0 gives CLEAR; "I" at byte 0 gives INIT. Trailing bytes are ignored for CLEAR and INIT.
  - x = 100*d2 + 10*d1 + d0, computed in 10 bits. x > X_MAX -> err RANGE(5).
  - Non-digit x or y, or y > Y_MAX -> err FIELD(4).
  - Font and character size:
    - ENG '2' -> 33; ENG '3' -> 73; MAR '3' -> 70.
    - MAR '2' or any other font byte -> err FONT(2).
  - cmd_len = index - 8. A TEXT frame with index <= 8 -> err FIELD(4).
  - Empty frame -> err EMPTY(6). Unknown tag -> err TAG(1).
  - Success -> PRESENT. Error -> err_pulse, then HUNT.
- Latency: cmd_valid or err_pulse rises on the second rising edge after the edge that accepts END_BYTE.
- PRESENT:
  - cmd_valid = 1; descriptor and buffer are frozen.
  - cmd_ready is sampled only while cmd_valid is high. On the edge with both high, cmd_valid goes to 0 and state returns to HUNT, so in_ready is 1 from the next cycle.
  - Input is not accepted, so bytes stall upstream and nothing is lost.
- char_rd_data:
  - Equals buf[char_rd_idx + 8].
  - An index >= cmd_len returns 8'h20.
  - The value is defined only while cmd_valid is high.
- Reset mid-frame or mid-PRESENT: immediate abort, no error pulse, returns to the reset values.
- START_BYTE with in_valid while in DECODE or PRESENT: not accepted, because in_ready is low.

Decomposition:
- Package oled_cmd_pkg:
  - op codes (INIT=1, CLEAR=2, TEXT=3), matching the driver's OPERATION encoding;
  - error codes;
  - field offsets (TAG=0, FONT=3, X2=4, X1=5, X0=6, Y=7, CHAR=8);
  - ASCII constants;
  - character-size constants (33, 73, 70);
  - state enumeration.
- Sub-module cmd_field_decode: combinational.
  - Inputs: buf bytes 0-7 and the index.
  - Outputs: op, lang, font, char_size, x, y, len, err, err_code.
  - The parent module holds the FSM, the buffer and the handshake.

Test Plan:
- 00 'E''N''G''2''0''5''0''3''H''i' FF, cmd_ready low -> 2 edges after FF: cmd_valid=1, op=3, lang=0, font=2, char_size=33, x=50, y=3, len=2; idx 0/1 read 'H'/'i'; idx 2 reads 20h; in_ready=0 until cmd_ready pulses.
- 00 'M''A''R''3''1''2''7''7''k' FF -> char_size=70, x=127, y=7, len=1. The same frame with x digits "128" -> err_pulse, code 5, no cmd_valid.
- 00 'C' FF, then 00 'I' FF -> op=2, then (after handshake) op=1. 00 FF -> err code 6.
- 00 followed by 32 non-delimiter bytes -> err code 3 on the 32nd byte; a subsequent well-formed frame parses correctly.
- 00 'E''N''G' 00 'C' FF -> the restart discards the partial frame; op=2, no error. Bytes before the first 00 are ignored.
- Reset asserted during COLLECT and during PRESENT -> all outputs at their reset values, no err_pulse; the next frame parses correctly.
